// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared types and constants for the pipeline control slice
package common_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_t;

  // One bundle of everything the controller drives into the pipeline registers
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  // Everything held: used in HALT and while reset is asserted
  localparam pipe_ctrl_t CTRL_IDLE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
  };

  // Free-running pipeline
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
  };

  // Hold PC and IF/ID, insert a NOP into EX so the load can reach MEM
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
  };

  // Redirect: load the new PC and squash the two younger instructions
  localparam pipe_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
  };

  // Data memory not ready: freeze front end and MEM, drain a bubble into WB
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1
  };

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
  import common_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // A load in EX writing a real register that the ID instruction reads
  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - stall/flush/freeze controller for a 5-stage pipeline
module pipeline_control
  import common_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic                  halted,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [1:0]            state
);

  // Wait counter only has to reach MEM_TIMEOUT
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q,     state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic              mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  pipe_ctrl_t ctrl;
  logic       load_use;
  logic       mem_freeze;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Output decode: memory freeze beats branch, branch beats load-use (ID is squashed anyway)
  always_comb begin
    ctrl       = CTRL_IDLE;
    mem_freeze = mem_req && !mem_ready;
    if (!rst) begin
      unique case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_freeze) begin
            ctrl = CTRL_FREEZE;
          end else if (ex_branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  // Next state, memory-wait timer and sticky timeout fault
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    unique case (state_q)
      ST_RUN: begin
        // Halt wins over a stall; the freeze is still driven this cycle by the decode above
        if (halt_req) begin
          state_d    = ST_HALT;
          wait_cnt_d = '0;
        end else if (mem_freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // A ready on the limit cycle still releases cleanly
        if (!mem_freeze) begin
          state_d    = halt_req ? ST_HALT : ST_RUN;
          wait_cnt_d = '0;
        end else if (halt_req) begin
          state_d    = ST_HALT;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= WAIT_LIMIT) begin
          state_d     = ST_HALT;
          wait_cnt_d  = '0;
          mem_fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating stall and flush event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != ST_HALT) && !ctrl.pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ctrl.if_id_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= mem_fault_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign halted        = (state_q == ST_HALT);
  assign mem_fault     = mem_fault_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - scoreboard bench for pipeline_control
module tb_pipeline_control;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [7:0] C_OFF = 8'b00000000;
  localparam logic [7:0] C_RUN = 8'b11111000;
  localparam logic [7:0] C_LU  = 8'b00111010;
  localparam logic [7:0] C_BR  = 8'b11111110;
  localparam logic [7:0] C_FRZ = 8'b00001001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble, halted, mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  pipeline_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted), .mem_fault(mem_fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] ctl;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [7:0] ctl_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic br, input logic mq,
                       input logic mrdy, input logic hr);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = ld; ex_branch_taken = br;
    mem_req = mq; mem_ready = mrdy; halt_req = hr;
  endtask

  // f = {load_use, branch, mem_req, mem_ready, halt_req}; non-hazard loads target x6
  task automatic apply(input logic [4:0] f);
    drive(5'd3, 5'd5, 1'b1, 1'b1, f[4] ? 5'd5 : 5'd6, 1'b1, f[3], f[2], f[1], f[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(5'b00000);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    apply(5'b01100);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exp_t'{$sformatf("reset_ctl_%0d", i), C_OFF, 2'd0});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      tests_run++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || halted !== 1'b0 || mem_fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_regs: stall=%0d flush=%0d halted=%b fault=%b expected all 0", stall_cnt, flush_cnt, halted, mem_fault);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    apply(5'b00000);
    sb.push_back(exp_t'{"reset_release", C_RUN, 2'd0});
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if (ctl_vec() !== e.ctl || state !== e.st) begin
      tests_failed++;
      $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [4:0] rs1 [6] = '{5'd3, 5'd7, 5'd7, 5'd5, 5'd0, 5'd9};
    logic [4:0] rs2 [6] = '{5'd5, 5'd2, 5'd2, 5'd5, 5'd0, 5'd4};
    logic       u1  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       u2  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] rd  [6] = '{5'd5, 5'd7, 5'd7, 5'd5, 5'd0, 5'd4};
    logic       ld  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       lu  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [CNT_W-1:0] exp_stall = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(rs1[i], rs2[i], u1[i], u2[i], rd[i], ld[i], 1'b0, 1'b0, 1'b0, 1'b0);
      sb.push_back(exp_t'{$sformatf("load_use_%0d", i), lu[i] ? C_LU : C_RUN, 2'd0});
      if (lu[i]) exp_stall = exp_stall + 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== exp_stall || flush_cnt !== 4'd0) begin
        tests_failed++;
        $display("FAIL load_use_cnt_%0d: stall=%0d flush=%0d expected stall=%0d flush=0", i, stall_cnt, flush_cnt, exp_stall);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    logic [4:0]       f     [4] = '{5'b11000, 5'b01000, 5'b10000, 5'b00000};
    logic [7:0]       ctl_e [4] = '{C_BR, C_BR, C_LU, C_RUN};
    logic [CNT_W-1:0] stl_e [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
    logic [CNT_W-1:0] fl_e  [4] = '{4'd1, 4'd2, 4'd2, 4'd2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(f[i]);
      sb.push_back(exp_t'{$sformatf("branch_%0d", i), ctl_e[i], 2'd0});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== stl_e[i] || flush_cnt !== fl_e[i]) begin
        tests_failed++;
        $display("FAIL branch_cnt_%0d: stall=%0d flush=%0d expected stall=%0d flush=%0d", i, stall_cnt, flush_cnt, stl_e[i], fl_e[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    logic [4:0]       f     [5] = '{5'b00100, 5'b11100, 5'b00100, 5'b01110, 5'b00000};
    logic [7:0]       ctl_e [5] = '{C_FRZ, C_FRZ, C_FRZ, C_BR, C_RUN};
    logic [1:0]       st_e  [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [CNT_W-1:0] stl_e [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    logic [CNT_W-1:0] fl_e  [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(f[i]);
      sb.push_back(exp_t'{$sformatf("mem_wait_%0d", i), ctl_e[i], st_e[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== stl_e[i] || flush_cnt !== fl_e[i]) begin
        tests_failed++;
        $display("FAIL mem_wait_cnt_%0d: stall=%0d flush=%0d expected stall=%0d flush=%0d", i, stall_cnt, flush_cnt, stl_e[i], fl_e[i]);
      end
    end
    tests_run++;
    if (state !== 2'd0) begin
      tests_failed++;
      $display("FAIL mem_wait_exit: state=%0d expected 0", state);
    end
  endtask

  task automatic test_timeout_ready_wins();
    exp_t e;
    logic [4:0]       f     [6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00110, 5'b00000};
    logic [7:0]       ctl_e [6] = '{C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_RUN, C_RUN};
    logic [1:0]       st_e  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [CNT_W-1:0] stl_e [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(f[i]);
      sb.push_back(exp_t'{$sformatf("ready_wins_%0d", i), ctl_e[i], st_e[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== stl_e[i]) begin
        tests_failed++;
        $display("FAIL ready_wins_cnt_%0d: stall=%0d expected %0d", i, stall_cnt, stl_e[i]);
      end
    end
    tests_run++;
    if (mem_fault !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_wins_fault: fault=%b halted=%b expected 0 0", mem_fault, halted);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [4:0]       f     [7] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01100, 5'b01100};
    logic [7:0]       ctl_e [7] = '{C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_FRZ, C_OFF, C_OFF};
    logic [1:0]       st_e  [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [CNT_W-1:0] stl_e [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(f[i]);
      sb.push_back(exp_t'{$sformatf("timeout_%0d", i), ctl_e[i], st_e[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== stl_e[i] || flush_cnt !== 4'd0) begin
        tests_failed++;
        $display("FAIL timeout_cnt_%0d: stall=%0d flush=%0d expected stall=%0d flush=0", i, stall_cnt, flush_cnt, stl_e[i]);
      end
    end
    tests_run++;
    if (mem_fault !== 1'b1 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_fault: fault=%b halted=%b expected 1 1", mem_fault, halted);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (state !== 2'd0 || halted !== 1'b0 || mem_fault !== 1'b0 || stall_cnt !== 4'd0 || ctl_vec() !== C_OFF) begin
      tests_failed++;
      $display("FAIL async_reset: state=%0d halted=%b fault=%b stall=%0d ctl=%b expected 0 0 0 0 %b",
               state, halted, mem_fault, stall_cnt, ctl_vec(), C_OFF);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    apply(5'b00000);
    sb.push_back(exp_t'{"timeout_resume", C_RUN, 2'd0});
    @(negedge clk);
    e = sb.pop_front();
    tests_run++;
    if (ctl_vec() !== e.ctl || state !== e.st) begin
      tests_failed++;
      $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    exp_t e;
    logic [4:0]       f     [4] = '{5'b01001, 5'b00000, 5'b00101, 5'b00100};
    logic [7:0]       ctl_e [4] = '{C_BR, C_OFF, C_FRZ, C_OFF};
    logic [1:0]       st_e  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [CNT_W-1:0] stl_e [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
    logic [CNT_W-1:0] fl_e  [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 2) do_reset();
      apply(f[i]);
      sb.push_back(exp_t'{$sformatf("halt_%0d", i), ctl_e[i], st_e[i]});
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (ctl_vec() !== e.ctl || state !== e.st) begin
        tests_failed++;
        $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
      end
      @(posedge clk); #1;
      tests_run++;
      if (stall_cnt !== stl_e[i] || flush_cnt !== fl_e[i] || halted !== 1'b1 || mem_fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_regs_%0d: stall=%0d flush=%0d halted=%b fault=%b expected %0d %0d 1 0",
                 i, stall_cnt, flush_cnt, halted, mem_fault, stl_e[i], fl_e[i]);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [CNT_W-1:0] exp_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      exp_cnt = '0;
      for (int i = 0; i < 20; i++) begin
        apply(pass == 0 ? 5'b01000 : 5'b10000);
        sb.push_back(exp_t'{$sformatf("sat_%0d_%0d", pass, i), pass == 0 ? C_BR : C_LU, 2'd0});
        if (i < 15) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (ctl_vec() !== e.ctl || state !== e.st) begin
          tests_failed++;
          $display("FAIL %s: ctl=%b state=%0d expected ctl=%b state=%0d", e.name, ctl_vec(), state, e.ctl, e.st);
        end
        @(posedge clk); #1;
        tests_run++;
        if ((pass == 0 ? flush_cnt : stall_cnt) !== exp_cnt) begin
          tests_failed++;
          $display("FAIL sat_cnt_%0d_%0d: count=%0d expected %0d", pass, i, pass == 0 ? flush_cnt : stall_cnt, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout_ready_wins();
    test_timeout();
    test_halt();
    test_saturation();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
